// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Purpose:
//   Owns the PC and keeps at most one instruction-memory request in flight.
//   The fetched word goes to decode as {instruction, PC, valid}. Decode
//   resolves branches, jumps, exceptions and interrupts, and those redirects
//   are applied here. The hazard unit can stall the stage.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   Stall                 hold PC and IF/ID (an in-flight response is captured)
//   Branch, BranchCond    conditional branch in ID and its outcome
//   Jump[1:0]             00 none, 01/11 j/jal, 10 jr/jalr
//   JumpTarget            branch / j / jal target
//   JumpRegTarget         forwarded rs value for jr/jalr
//   Exception             undefined instruction in ID
//   Interrupt             level interrupt request (ignored in kernel mode)
//   imem_req, imem_addr   fetch request, address = PC
//   imem_valid, imem_rdata  fetch response
//   IFID_Instruction, IFID_PC, IFID_Valid  pipeline register to decode
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        BranchCond,
  input  logic [1:0]  Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JumpRegTarget,
  input  logic        Exception,
  input  logic        Interrupt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PC,
  output logic        IFID_Valid
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] holdInstr;

  logic        irqTake;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] pcPlus4;
  logic        waitingResp;
  logic        stillOutstanding;

  // Kernel mode (PC[31]=1) is never interrupted.
  assign irqTake = Interrupt & ~pc[31];

  // Exception and interrupt act even while stalled; control-flow redirects
  // from decode are only valid when ID is not stalled.
  assign redirect = Exception | irqTake |
                    (~Stall & ((Jump != 2'b00) | (Branch & BranchCond)));

  always_comb begin
    redirectPc = JumpTarget;
    if (Exception) begin
      redirectPc = ILLOP_PC;
    end else if (irqTake) begin
      redirectPc = XADR_PC;
    end else if (Jump == 2'b10) begin
      redirectPc = JumpRegTarget;
    end
  end

  // Increment within the current address space; PC[31] never changes here.
  assign pcPlus4 = {pc[31], pc[30:0] + 31'd4};

  // A response is only sampled in states that have a request outstanding.
  assign waitingResp = (state == S_WAIT) | (state == S_DISCARD);

  // True when, after this edge, memory still owes us a response: either the
  // request issued this cycle or one that has not answered yet. A redirect
  // must then park in S_DISCARD to swallow it.
  assign stillOutstanding = (state == S_REQ) | (waitingResp & ~imem_valid);

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      holdInstr        <= 32'h0;
      IFID_Instruction <= 32'h0;
      IFID_PC          <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (redirect) begin
      // No delay slot: whatever was fetched or held is dropped.
      pc               <= redirectPc;
      IFID_Instruction <= 32'h0;
      IFID_PC          <= 32'h0;
      IFID_Valid       <= 1'b0;
      state            <= stillOutstanding ? S_DISCARD : S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          state <= S_WAIT;
          if (!Stall) begin
            IFID_Instruction <= 32'h0;
            IFID_PC          <= 32'h0;
            IFID_Valid       <= 1'b0;
          end
        end

        S_WAIT: begin
          if (imem_valid) begin
            if (!Stall) begin
              IFID_Instruction <= imem_rdata;
              IFID_PC          <= pc;
              IFID_Valid       <= 1'b1;
              pc               <= pcPlus4;
              state            <= S_REQ;
            end else begin
              // Decode cannot accept yet; park the word until the stall lifts.
              holdInstr <= imem_rdata;
              state     <= S_HOLD;
            end
          end else if (!Stall) begin
            IFID_Instruction <= 32'h0;
            IFID_PC          <= 32'h0;
            IFID_Valid       <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!Stall) begin
            IFID_Instruction <= holdInstr;
            IFID_PC          <= pc;
            IFID_Valid       <= 1'b1;
            pc               <= pcPlus4;
            state            <= S_REQ;
          end
        end

        S_DISCARD: begin
          // The stale response belongs to an abandoned path; drop its data.
          if (imem_valid) begin
            state <= S_REQ;
          end
          if (!Stall) begin
            IFID_Instruction <= 32'h0;
            IFID_PC          <= 32'h0;
            IFID_Valid       <= 1'b0;
          end
        end

        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with reference model
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall, Branch, BranchCond, Exception, Interrupt;
  logic [1:0]  Jump;
  logic [31:0] JumpTarget, JumpRegTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_Instruction, IFID_PC;
  logic        IFID_Valid;

  if_stage #(
    .RESET_PC(RESET_PC),
    .ILLOP_PC(ILLOP_PC),
    .XADR_PC (XADR_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Stall           (Stall),
    .Branch          (Branch),
    .BranchCond      (BranchCond),
    .Jump            (Jump),
    .JumpTarget      (JumpTarget),
    .JumpRegTarget   (JumpRegTarget),
    .Exception       (Exception),
    .Interrupt       (Interrupt),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PC         (IFID_PC),
    .IFID_Valid      (IFID_Valid)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Reference model: fetch-level view of the stage.
  logic [31:0] mPc, mIfInstr, mIfPc, mHeldInstr;
  logic        mIfValid, mReqNow, mInFlight, mDrop, mHeld;

  // Memory responder.
  logic        memBusy  = 1'b0;
  logic        memStale = 1'b0;
  int          memDelay = 0;
  int          memLat   = 1;
  logic [31:0] memAddr  = 32'h0;

  logic [31:0] reqLog[$];
  logic [31:0] ifPcLog[$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD_0001;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mIfInstr = 0; mIfPc = 0; mIfValid = 0;
    mReqNow = 1; mInFlight = 0; mDrop = 0; mHeld = 0; mHeldInstr = 0;
  endtask

  task automatic modelStep();
    logic irqT, redir, outstanding, arrives, haveNew;
    logic [31:0] tgt, newInstr;
    irqT  = Interrupt && !mPc[31];
    redir = Exception || irqT || (!Stall && (Jump != 0 || (Branch && BranchCond)));
    tgt   = Exception ? ILLOP_PC : irqT ? XADR_PC : (Jump == 2) ? JumpRegTarget : JumpTarget;
    arrives     = imem_valid && mInFlight;
    outstanding = mReqNow || (mInFlight && !imem_valid);
    if (redir) begin
      mPc = tgt; mIfInstr = 0; mIfPc = 0; mIfValid = 0; mHeld = 0;
      mInFlight = outstanding; mDrop = outstanding; mReqNow = !outstanding;
    end else begin
      haveNew = 0; newInstr = 0;
      if (arrives && !mDrop) begin haveNew = 1; newInstr = imem_rdata; end
      else if (mHeld) begin haveNew = 1; newInstr = mHeldInstr; end
      if (haveNew) begin
        mInFlight = 0;
        if (!Stall) begin
          mIfInstr = newInstr; mIfPc = mPc; mIfValid = 1;
          mPc = {mPc[31], 31'(mPc[30:0] + 31'd4)};
          mHeld = 0; mReqNow = 1;
        end else begin
          mHeld = 1; mHeldInstr = newInstr; mReqNow = 0;
        end
      end else begin
        if (!Stall) begin mIfInstr = 0; mIfPc = 0; mIfValid = 0; end
        if (arrives) begin mInFlight = 0; mDrop = 0; mReqNow = 1; end
        else if (mReqNow) begin mInFlight = 1; mDrop = 0; mReqNow = 0; end
      end
    end
  endtask

  // One cycle: compare outputs, play memory, advance model, go to next negedge.
  task automatic tick();
    check("imem_req", 32'(imem_req), 32'(mReqNow));
    check("imem_addr", imem_addr, mPc);
    check("IFID_Instruction", IFID_Instruction, mIfInstr);
    check("IFID_PC", IFID_PC, mIfPc);
    check("IFID_Valid", 32'(IFID_Valid), 32'(mIfValid));
    if (imem_req) reqLog.push_back(imem_addr);
    if (IFID_Valid) ifPcLog.push_back(IFID_PC);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (memBusy) begin
      memDelay--;
      if (memDelay == 0) begin
        imem_valid = 1'b1;
        imem_rdata = memStale ? 32'hBAD0_0000 : memData(memAddr);
        memBusy = 1'b0;
      end
    end
    if (imem_req) begin
      check("single_outstanding", 32'(memBusy), 32'h0);
      memBusy  = 1'b1;
      memStale = 1'b0;
      memAddr  = imem_addr;
      memDelay = (memLat != 0) ? memLat : int'($urandom_range(1, 3));
    end
    modelStep();
    @(negedge clk);
  endtask

  task automatic clearCtl();
    Stall = 0; Branch = 0; BranchCond = 0; Jump = 0; Exception = 0; Interrupt = 0;
    JumpTarget = 0; JumpRegTarget = 0;
  endtask

  task automatic jumpTo(input logic [31:0] a);
    Jump = 2'b01; JumpTarget = a;
    tick();
    clearCtl();
  endtask

  task automatic waitReq(input logic [31:0] a, input string nm);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin tick(); n++; end
    check(nm, 32'(imem_req && imem_addr == a), 32'h1);
  endtask

  task automatic nextReqAddr(output logic [31:0] a);
    int n = 0;
    while (!imem_req && n < 40) begin tick(); n++; end
    a = imem_req ? imem_addr : 32'hFFFF_FFFF;
  endtask

  task automatic randCtl();
    logic [31:0] t;
    clearCtl();
    Stall      = ($urandom % 4) == 0;
    Branch     = ($urandom % 100) < 8;
    BranchCond = $urandom % 2;
    if (($urandom % 100) < 6) Jump = 2'($urandom % 4);
    Exception  = ($urandom % 100) < 2;
    Interrupt  = ($urandom % 100) < 4;
    t = $urandom & 32'h7FFF_FFFC;
    if (($urandom % 8) == 0) t[31] = 1'b1;
    JumpTarget = t;
    t = $urandom & 32'h7FFF_FFFC;
    if (($urandom % 8) == 0) t[31] = 1'b1;
    JumpRegTarget = t;
  endtask

  initial begin
    logic [31:0] a;
    clearCtl();
    imem_valid = 0; imem_rdata = 0;
    reset = 0;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1;

    // Reset state and back-to-back fetches with 1-cycle memory.
    check("rst_IFID_Valid", 32'(IFID_Valid), 32'h0);
    check("rst_IFID_PC", IFID_PC, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h8000_0000);
    memLat = 1;
    repeat (5) tick();
    check("t1_req0", reqLog[0], 32'h8000_0000);
    check("t1_req1", reqLog[1], 32'h8000_0004);
    check("t1_req2", reqLog[2], 32'h8000_0008);
    check("t1_if0", ifPcLog[0], 32'h8000_0000);
    check("t1_if1", ifPcLog[1], 32'h8000_0004);

    // Stall across the response: held, delivered on release, no refetch.
    jumpTo(32'h0040_0010);
    waitReq(32'h0040_0010, "t2_reach");
    tick();
    Stall = 1;
    repeat (3) tick();
    Stall = 0;
    tick();
    check("t2_if_pc", IFID_PC, 32'h0040_0010);
    check("t2_if_instr", IFID_Instruction, 32'h0040_0010 ^ 32'hDEAD_0001);
    check("t2_if_valid", 32'(IFID_Valid), 32'h1);
    check("t2_next_addr", imem_addr, 32'h0040_0014);

    // Branch while waiting with no response: discard, then refetch target.
    memLat = 3;
    tick();
    Branch = 1; BranchCond = 1; JumpTarget = 32'h0040_0100;
    tick();
    clearCtl();
    check("t3_bubble", 32'(IFID_Valid), 32'h0);
    nextReqAddr(a);
    check("t3_next_req", a, 32'h0040_0100);

    // jr coincident with the response: response dropped, refetch at target.
    memLat = 2;
    tick();
    tick();
    Jump = 2'b10; JumpRegTarget = 32'h0040_1000;
    tick();
    clearCtl();
    check("t4_bubble", 32'(IFID_Valid), 32'h0);
    check("t4_req", 32'(imem_req), 32'h1);
    check("t4_addr", imem_addr, 32'h0040_1000);

    // Interrupts in user and kernel mode; exception beats jump.
    memLat = 1;
    jumpTo(32'h0040_0020);
    waitReq(32'h0040_0020, "t5_reach_user");
    Interrupt = 1;
    tick();
    clearCtl();
    check("t5_irq_user", imem_addr, 32'h8000_0008);
    jumpTo(32'h8000_0010);
    waitReq(32'h8000_0010, "t5_reach_kernel");
    tick();
    Interrupt = 1;
    tick();
    clearCtl();
    check("t5_irq_kernel", imem_addr, 32'h8000_0014);
    check("t5_kernel_if", IFID_PC, 32'h8000_0010);
    Exception = 1; Jump = 2'b01; JumpTarget = 32'h0040_0300;
    tick();
    clearCtl();
    check("t5_exc_jump", imem_addr, 32'h8000_0004);

    // PC increment stays in user space at the top boundary.
    jumpTo(32'h7FFF_FFFC);
    waitReq(32'h7FFF_FFFC, "t6_reach");
    tick();
    tick();
    check("t6_wrap_addr", imem_addr, 32'h0000_0000);
    check("t6_wrap_if", IFID_PC, 32'h7FFF_FFFC);

    // Asynchronous reset in the middle of a fetch; late response ignored.
    memLat = 2;
    nextReqAddr(a);
    tick();
    reset = 0;
    #1;
    check("t6_rst_instr", IFID_Instruction, 32'h0);
    check("t6_rst_pc", IFID_PC, 32'h0);
    check("t6_rst_valid", 32'(IFID_Valid), 32'h0);
    check("t6_rst_addr", imem_addr, 32'h8000_0000);
    @(negedge clk);
    memBusy = 1; memDelay = 1; memStale = 1;
    reset = 1;
    modelReset();
    repeat (3) tick();
    check("t6_restart_instr", IFID_Instruction, 32'h5EAD_0001);
    check("t6_restart_pc", IFID_PC, 32'h8000_0000);

    // Randomized traffic against the model.
    memLat = 0;
    for (int i = 0; i < 3000; i++) begin
      randCtl();
      tick();
    end
    clearCtl();
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
